// File: rtl/tpu_package.sv
// Shared widths and FSM encoding for the accumulator output path.
package tpu_package;
    localparam int MUL_SIZE = 32;
    localparam int ACC_W    = 32;
    localparam int OUT_W    = 8;
    localparam int ADDR_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } aou_state_t;
endpackage

// File: rtl/acc_quantize_lane.sv
// One lane of requantization: arithmetic right shift, optional ReLU, then
// saturation into the signed OUT_W output range.
module acc_quantize_lane
    import tpu_package::*;
(
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [4:0]       shift,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] q
);
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> shift;
        q       = shifted[OUT_W-1:0];
        if (relu_en && (shifted < 0)) begin
            q = '0;
        end else if (shifted > Q_MAX) begin
            q = Q_MAX[OUT_W-1:0];
        end else if (shifted < Q_MIN) begin
            q = Q_MIN[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/accumulator_output_unit.sv
// Drains accumulator rows, quantizes each lane and streams rows to the unified buffer.
//   state | meaning
//   IDLE  | waiting for start_i; rows_i==0 just pulses done_o
//   DRAIN | issuing accumulator reads while the 2-entry buffer has room
//   FLUSH | all reads issued; waiting for the last row to be accepted
module accumulator_output_unit
    import tpu_package::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [ADDR_W-1:0]           rows_i,
    input  logic [ADDR_W-1:0]           src_base_i,
    input  logic [ADDR_W-1:0]           dst_base_i,
    input  logic [4:0]                  shift_i,
    input  logic                        relu_en_i,
    output logic                        acc_rd_en_o,
    output logic [ADDR_W-1:0]           acc_rd_addr_o,
    input  logic [MUL_SIZE*ACC_W-1:0]   acc_rd_data_i,
    output logic                        ub_valid_o,
    input  logic                        ub_ready_i,
    output logic [ADDR_W-1:0]           ub_addr_o,
    output logic [MUL_SIZE*OUT_W-1:0]   ub_data_o,
    output logic                        busy_o,
    output logic                        done_o
);
    aou_state_t                 state;
    logic [ADDR_W-1:0]          rows, src_base, dst_base, rd_cnt, wr_cnt;
    logic [4:0]                 shift;
    logic                       relu_en;
    logic                       rd_vld;
    logic [MUL_SIZE*OUT_W-1:0]  fifo_data [2];
    logic [ADDR_W-1:0]          fifo_addr [2];
    logic                       wptr, rptr;
    logic [1:0]                 count;
    logic [MUL_SIZE*OUT_W-1:0]  quant_row;
    logic                       push, pop, issue;
    logic [2:0]                 occ_after_pop;

    for (genvar i = 0; i < MUL_SIZE; i++) begin : g_lane
        acc_quantize_lane u_lane (
            .acc     (acc_rd_data_i[i*ACC_W +: ACC_W]),
            .shift   (shift),
            .relu_en (relu_en),
            .q       (quant_row[i*OUT_W +: OUT_W])
        );
    end

    // Occupancy is counted net of this cycle's pop so a steady ready stream
    // keeps one read per cycle without ever holding more than two rows.
    assign push          = rd_vld;
    assign pop           = ub_valid_o && ub_ready_i;
    assign occ_after_pop = 3'(count) + 3'(rd_vld) - 3'(pop);
    assign issue         = (state == DRAIN) && (occ_after_pop < 3'd2);

    assign acc_rd_en_o   = issue;
    assign acc_rd_addr_o = src_base + rd_cnt;
    assign ub_valid_o    = (count != 2'd0);
    assign ub_addr_o     = fifo_addr[rptr];
    assign ub_data_o     = fifo_data[rptr];
    assign busy_o        = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            rows     <= '0;
            src_base <= '0;
            dst_base <= '0;
            shift    <= '0;
            relu_en  <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            rd_vld   <= 1'b0;
            done_o   <= 1'b0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            rd_vld <= issue;

            if (pop) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
                rptr   <= ~rptr;
            end
            // Returning data belongs to read rd_cnt-1, which is already counted.
            if (push) begin
                fifo_data[wptr] <= quant_row;
                fifo_addr[wptr] <= dst_base + rd_cnt - ADDR_W'(1);
                wptr            <= ~wptr;
            end
            count <= count + 2'(push) - 2'(pop);

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (rows_i != '0) begin
                            rows     <= rows_i;
                            src_base <= src_base_i;
                            dst_base <= dst_base_i;
                            shift    <= shift_i;
                            relu_en  <= relu_en_i;
                            rd_cnt   <= '0;
                            wr_cnt   <= '0;
                            state    <= DRAIN;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + ADDR_W'(1);
                        if (rd_cnt == rows - ADDR_W'(1)) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && (wr_cnt == rows - ADDR_W'(1))) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accumulator_output_unit.sv
// Randomized bench for accumulator_output_unit against an arithmetic reference model.
module tb_accumulator_output_unit;
    import tpu_package::*;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       start_i;
    logic [ADDR_W-1:0]          rows_i, src_base_i, dst_base_i;
    logic [4:0]                 shift_i;
    logic                       relu_en_i;
    logic                       acc_rd_en_o;
    logic [ADDR_W-1:0]          acc_rd_addr_o;
    logic [MUL_SIZE*ACC_W-1:0]  acc_rd_data_i;
    logic                       ub_valid_o, ub_ready_i;
    logic [ADDR_W-1:0]          ub_addr_o;
    logic [MUL_SIZE*OUT_W-1:0]  ub_data_o;
    logic                       busy_o, done_o;

    accumulator_output_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i),
        .src_base_i(src_base_i), .dst_base_i(dst_base_i), .shift_i(shift_i),
        .relu_en_i(relu_en_i), .acc_rd_en_o(acc_rd_en_o), .acc_rd_addr_o(acc_rd_addr_o),
        .acc_rd_data_i(acc_rd_data_i), .ub_valid_o(ub_valid_o), .ub_ready_i(ub_ready_i),
        .ub_addr_o(ub_addr_o), .ub_data_o(ub_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0]         addr;
        logic [MUL_SIZE*OUT_W-1:0] data;
        int                        c;
    } xfer_t;

    logic [MUL_SIZE*ACC_W-1:0] mem [1 << ADDR_W];
    xfer_t xq[$];
    int    rd_addr_q[$], rd_cyc_q[$], done_q[$], start_q[$];
    int    cyc = 0, first_valid = -1;
    int    checks = 0, failures = 0;
    bit    busy_first_rd, busy_at_done;
    bit    occ_en = 0;
    int    rd_total, rd_lag, xf_total, max_occ, vld_err, stab_err;
    bit    prev_stall = 0;
    logic [ADDR_W-1:0]         prev_addr;
    logic [MUL_SIZE*OUT_W-1:0] prev_data;
    bit    rd_pend = 0;
    logic [ADDR_W-1:0]         rd_pend_addr;

    // Observation at the falling edge, away from the DUT's active edge.
    always @(negedge clk_i) begin
        int occ;
        if (rst_i) begin
            if (start_i) start_q.push_back(cyc);
            if (acc_rd_en_o) begin
                if (rd_addr_q.size() == 0) busy_first_rd = busy_o;
                rd_addr_q.push_back(int'(acc_rd_addr_o));
                rd_cyc_q.push_back(cyc);
            end
            if (ub_valid_o && first_valid < 0) first_valid = cyc;
            if (ub_valid_o && ub_ready_i) xq.push_back('{ub_addr_o, ub_data_o, cyc});
            if (done_o) begin
                done_q.push_back(cyc);
                busy_at_done = busy_o;
            end
            if (prev_stall && (!ub_valid_o || ub_addr_o !== prev_addr || ub_data_o !== prev_data))
                stab_err++;
            prev_stall = ub_valid_o && !ub_ready_i;
            prev_addr  = ub_addr_o;
            prev_data  = ub_data_o;
            if (occ_en) begin
                // rows buffered = reads at least two cycles old minus rows accepted
                occ = rd_lag - xf_total;
                if (occ > max_occ) max_occ = occ;
                if ((occ > 0) != ub_valid_o) vld_err++;
                rd_lag = rd_total;
                if (acc_rd_en_o) rd_total++;
                if (ub_valid_o && ub_ready_i) xf_total++;
            end
        end else begin
            prev_stall = 0;
        end
        rd_pend      = acc_rd_en_o && rst_i;
        rd_pend_addr = acc_rd_addr_o;
        cyc++;
    end

    // Accumulator memory: data appears for the cycle after the read strobe.
    always @(posedge clk_i) begin
        #1;
        if (rd_pend) acc_rd_data_i = mem[rd_pend_addr];
    end

    function automatic int quant(longint x, int sh, bit relu);
        longint d = longint'(1) << sh;
        longint v;
        v = (x >= 0) ? x / d : -((-x + d - 1) / d);
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    function automatic logic [MUL_SIZE*OUT_W-1:0] exp_row(logic [MUL_SIZE*ACC_W-1:0] r, int sh, bit relu);
        logic [MUL_SIZE*OUT_W-1:0] res;
        logic signed [ACC_W-1:0]   lane;
        res = '0;
        for (int l = 0; l < MUL_SIZE; l++) begin
            lane = r[l*ACC_W +: ACC_W];
            res[l*OUT_W +: OUT_W] = OUT_W'(quant(longint'(lane), sh, relu));
        end
        return res;
    endfunction

    function automatic int rand_lane();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 600)) - 300;
            1:       return int'($urandom_range(0, 10000)) - 5000;
            2:       return int'($urandom_range(0, 2000000)) - 1000000;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic fill_rows(input logic [ADDR_W-1:0] src, input int rows);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < rows; i++) begin
            a = src + ADDR_W'(i);
            for (int l = 0; l < MUL_SIZE; l++) mem[a][l*ACC_W +: ACC_W] = rand_lane();
        end
    endtask

    task automatic clear_obs();
        xq.delete(); rd_addr_q.delete(); rd_cyc_q.delete(); done_q.delete(); start_q.delete();
        first_valid = -1; rd_total = 0; rd_lag = 0; xf_total = 0;
        max_occ = 0; vld_err = 0; stab_err = 0;
        busy_first_rd = 0; busy_at_done = 1;
    endtask

    task automatic pulse_start(input int rows, input logic [ADDR_W-1:0] src, dst,
                               input int sh, input bit relu);
        rows_i = ADDR_W'(rows); src_base_i = src; dst_base_i = dst;
        shift_i = 5'(sh); relu_en_i = relu;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random ready
    task automatic run_drain(input int rows, input logic [ADDR_W-1:0] src, dst,
                             input int sh, input bit relu, input int mode,
                             input bit glitch, input string name);
        logic [MUL_SIZE*OUT_W-1:0] exp_d;
        logic [ADDR_W-1:0]         exp_a;
        int k, last_c;
        clear_obs();
        occ_en = 1;
        ub_ready_i = 1'b1;
        pulse_start(rows, src, dst, sh, relu);
        for (k = 0; k < 400 && done_q.size() == 0; k++) begin
            case (mode)
                0:       ub_ready_i = 1'b1;
                1:       ub_ready_i = (k % 4 == 0) || (k % 4 == 3);
                default: ub_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (glitch && k == 2) begin
                start_i = 1'b1; rows_i = ADDR_W'(1); src_base_i = '0; dst_base_i = '0;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        ub_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        occ_en = 0;

        checks++;
        if (done_q.size() != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d expected 1", name, done_q.size());
        end
        checks++;
        if (xq.size() != rows) begin
            failures++;
            $display("FAIL %s xfer_count: got %0d expected %0d", name, xq.size(), rows);
        end
        checks++;
        if (rd_addr_q.size() != rows) begin
            failures++;
            $display("FAIL %s read_count: got %0d expected %0d", name, rd_addr_q.size(), rows);
        end
        for (int i = 0; i < rows && i < xq.size(); i++) begin
            exp_a = dst + ADDR_W'(i);
            exp_d = exp_row(mem[src + ADDR_W'(i)], sh, relu);
            checks++;
            if (xq[i].addr !== exp_a) begin
                failures++;
                $display("FAIL %s ub_addr[%0d]: got %0h expected %0h", name, i, xq[i].addr, exp_a);
            end
            checks++;
            if (xq[i].data !== exp_d) begin
                failures++;
                $display("FAIL %s ub_data[%0d]: got %0h expected %0h", name, i, xq[i].data, exp_d);
            end
        end
        for (int i = 0; i < rows && i < rd_addr_q.size(); i++) begin
            exp_a = src + ADDR_W'(i);
            checks++;
            if (rd_addr_q[i] != int'(exp_a)) begin
                failures++;
                $display("FAIL %s rd_addr[%0d]: got %0h expected %0h", name, i, rd_addr_q[i], exp_a);
            end
        end
        last_c = (xq.size() > 0) ? xq[xq.size()-1].c : -100;
        checks++;
        if (done_q.size() == 0 || done_q[0] != last_c + 1) begin
            failures++;
            $display("FAIL %s done_timing: got %0d expected %0d", name,
                     (done_q.size() > 0) ? done_q[0] : -1, last_c + 1);
        end
        checks++;
        if (rd_cyc_q.size() == 0 || first_valid != rd_cyc_q[0] + 2) begin
            failures++;
            $display("FAIL %s first_valid_latency: got %0d expected %0d", name, first_valid,
                     (rd_cyc_q.size() > 0) ? rd_cyc_q[0] + 2 : -1);
        end
        checks++;
        if (busy_first_rd !== 1'b1 || busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: got %0b/%0b expected 1/0", name, busy_first_rd, busy_at_done);
        end
        checks++;
        if (max_occ > 2 || vld_err != 0) begin
            failures++;
            $display("FAIL %s occupancy: got max=%0d valid_err=%0d expected max<=2 err=0",
                     name, max_occ, vld_err);
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL %s stall_stability: got %0d changes expected 0", name, stab_err);
        end
        if (mode == 0) begin
            for (int i = 1; i < xq.size(); i++) begin
                checks++;
                if (xq[i].c != xq[0].c + i) begin
                    failures++;
                    $display("FAIL %s throughput[%0d]: got cycle %0d expected %0d",
                             name, i, xq[i].c, xq[0].c + i);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({acc_rd_en_o, ub_valid_o, busy_o, done_o} !== 4'b0 || acc_rd_addr_o !== '0 ||
            ub_addr_o !== '0 || ub_data_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%0b vld=%0b busy=%0b done=%0b ra=%0h ua=%0h expected all 0",
                     acc_rd_en_o, ub_valid_o, busy_o, done_o, acc_rd_addr_o, ub_addr_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic();
        int     vals[4] = '{5, -3, 200, -200};
        logic [7:0] lane0_exp[4] = '{8'd5, 8'hFD, 8'h7F, 8'h80};
        fill_rows(10'h000, 4);
        for (int i = 0; i < 4; i++) mem[ADDR_W'(i)][ACC_W-1:0] = vals[i];
        run_drain(4, 10'h000, 10'h100, 0, 1'b0, 0, 1'b0, "basic");
        for (int i = 0; i < 4 && i < xq.size(); i++) begin
            checks++;
            if (xq[i].data[7:0] !== lane0_exp[i]) begin
                failures++;
                $display("FAIL basic_lane0[%0d]: got %0h expected %0h", i, xq[i].data[7:0], lane0_exp[i]);
            end
        end
    endtask

    task automatic test_quant();
        fill_rows(10'h020, 2);
        mem[10'h020][31:0] = 32'h0000_0130;
        mem[10'h020][63:32] = -32'sh130;
        run_drain(2, 10'h020, 10'h040, 4, 1'b1, 0, 1'b0, "quant");
        checks++;
        if (xq.size() < 1 || xq[0].data[15:0] !== 16'h0013) begin
            failures++;
            $display("FAIL quant_lanes: got %0h expected 0013", (xq.size() > 0) ? xq[0].data[15:0] : 16'hx);
        end
    endtask

    task automatic test_zero_rows();
        clear_obs();
        pulse_start(0, 10'h055, 10'h066, 0, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        checks++;
        if (done_q.size() != 1 || start_q.size() != 1 || done_q[0] != start_q[0] + 1) begin
            failures++;
            $display("FAIL zero_rows_done: got %0d pulses expected 1 at start+1", done_q.size());
        end
        checks++;
        if (rd_addr_q.size() != 0 || first_valid >= 0 || xq.size() != 0) begin
            failures++;
            $display("FAIL zero_rows_activity: got reads=%0d valid_at=%0d expected none",
                     rd_addr_q.size(), first_valid);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_obs();
        fill_rows(10'h010, 6);
        ub_ready_i = 1'b1;
        pulse_start(6, 10'h010, 10'h200, 0, 1'b0);
        for (k = 0; k < 50 && xq.size() < 2; k++) begin
            @(posedge clk_i); #1;
        end
        checks++;
        if (xq.size() != 2) begin
            failures++;
            $display("FAIL reset_mid_progress: got %0d xfers expected 2", xq.size());
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if ({acc_rd_en_o, ub_valid_o, busy_o, done_o} !== 4'b0 || ub_data_o !== '0 ||
            ub_addr_o !== '0 || acc_rd_addr_o !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got en=%0b vld=%0b busy=%0b done=%0b expected 0",
                     acc_rd_en_o, ub_valid_o, busy_o, done_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        clear_obs();
        repeat (12) @(posedge clk_i);
        #1;
        checks++;
        if (done_q.size() != 0 || xq.size() != 0 || rd_addr_q.size() != 0 || first_valid >= 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got done=%0d xfers=%0d reads=%0d expected 0",
                     done_q.size(), xq.size(), rd_addr_q.size());
        end
        fill_rows(10'h030, 6);
        run_drain(6, 10'h030, 10'h210, 2, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int rows, sh;
        logic [ADDR_W-1:0] src, dst;
        for (int t = 0; t < 6; t++) begin
            rows = $urandom_range(3, 10);
            src  = ADDR_W'($urandom);
            dst  = ADDR_W'($urandom);
            sh   = $urandom_range(0, 15);
            fill_rows(src, rows);
            run_drain(rows, src, dst, sh, 1'($urandom_range(0, 1)), t % 3, t == 1, "random");
        end
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; ub_ready_i = 1'b0;
        rows_i = '0; src_base_i = '0; dst_base_i = '0; shift_i = '0; relu_en_i = 1'b0;
        acc_rd_data_i = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        clear_obs();
        test_reset();
        test_basic();
        test_quant();
        fill_rows(10'h080, 8);
        run_drain(8, 10'h080, 10'h180, 1, 1'b0, 1, 1'b0, "stall");
        test_zero_rows();
        fill_rows(10'h3FE, 4);
        run_drain(4, 10'h3FE, 10'h3FF, 0, 1'b0, 0, 1'b0, "wrap");
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
